mac_array_sequencer: RTL and testbench

- Control block for a ROWS x COLS systolic grid of multiply-accumulate cells.
- Per command:
  - clears the accumulators;
  - streams k_len operand pairs from the A and B operand buffers;
  - gates each cell's accumulate with the correct systolic skew;
  - hands results out one row per valid/ready beat.
- Sits between the command issuer and the MAC array plus operand buffers.

---
 rtl/mac_array_sequencer_pkg.sv | 39 +++
 rtl/mac_array_sequencer_if.sv | 49 ++++
 rtl/mac_array_sequencer_skew_valid_pipe.sv | 44 ++++
 rtl/mac_array_sequencer.sv | 147 ++++++++++++++
 tb/tb_mac_array_sequencer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_array_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_ctrl_pkg
// Description : Shared types and helpers for the MAC array sequencer:
//               sequencer state encoding, default grid geometry, skew
//               pipeline depth and a width helper for row indices.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mac_ctrl_pkg;

    // Sequencer states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_OUTPUT = 3'd4
    } state_e;

    localparam int DEF_ROWS       = 4;
    localparam int DEF_COLS       = 4;
    localparam int DEF_K_WIDTH    = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    // Deepest skew tap needed: cell (ROWS-1, COLS-1) lags by ROWS+COLS-1.
    localparam int SKEW_DEPTH = DEF_ROWS + DEF_COLS - 1;

    function automatic int skew_depth(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

    // $clog2 with a floor of 1 so a single-row grid still gets a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : mac_ctrl_pkg
`default_nettype wire

// File: rtl/mac_array_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_array_sequencer_if
// Description : Bundles the command, operand-buffer, MAC-array control and
//               result handshake signals of the sequencer.
// Ports       : start/k_len (command), busy/done (status),
//               a_rd_en/b_rd_en/rd_addr (operand buffers),
//               mac_clear/mac_hold (array control),
//               out_valid/out_ready/out_row (result row handshake).
//               master = command issuer / consumer side, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_array_sequencer_if
    import mac_ctrl_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int K_WIDTH    = DEF_K_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    localparam int ROW_W = clog2_min1(ROWS);

    logic                   start;
    logic [K_WIDTH-1:0]     k_len;
    logic                   busy;
    logic                   done;
    logic                   a_rd_en;
    logic                   b_rd_en;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic                   mac_clear;
    logic [ROWS*COLS-1:0]   mac_hold;
    logic                   out_valid;
    logic                   out_ready;
    logic [ROW_W-1:0]       out_row;

    modport master (
        output start, k_len, out_ready,
        input  busy, done, a_rd_en, b_rd_en, rd_addr,
               mac_clear, mac_hold, out_valid, out_row
    );

    modport slave (
        input  start, k_len, out_ready,
        output busy, done, a_rd_en, b_rd_en, rd_addr,
               mac_clear, mac_hold, out_valid, out_row
    );

endinterface : mac_array_sequencer_if
`default_nettype wire

// File: rtl/mac_array_sequencer_skew_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : skew_valid_pipe
// Description : Shift register producing delayed copies d[1..DEPTH] of the
//               operand read strobe, used to skew per-cell accumulate enables.
// Ports       : clk, reset (async, active-high)
//               rd_en_i  - read strobe being delayed
//               d_o      - d_o[i] is rd_en_i delayed by i cycles
//               empty_o  - high when every tap will be 0 after the next edge
// Revision    : 1.0 - initial release
// ============================================================================
module skew_valid_pipe
    import mac_ctrl_pkg::*;
#(
    parameter int DEPTH = SKEW_DEPTH
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           rd_en_i,
    output logic [DEPTH:1]      d_o,
    output logic                empty_o
);

    logic [DEPTH:1] d_q;
    // chain[0] is the live strobe, chain[i] is tap i; shifting drops tap DEPTH.
    logic [DEPTH:0] w_chain;

    assign w_chain = {d_q, rd_en_i};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= '0;
        end else begin
            d_q <= w_chain[DEPTH-1:0];
        end
    end

    // Look-ahead: lets the sequencer leave DRAIN on the same edge that clears
    // the last tap, so the first result row appears without a bubble.
    assign empty_o = ~|w_chain[DEPTH-1:0];
    assign d_o     = d_q;

endmodule : skew_valid_pipe
`default_nettype wire

// File: rtl/mac_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mac_array_sequencer
// Description : Control block for a ROWS x COLS systolic MAC grid. Per
//               command it clears the accumulators, streams k_len operand
//               pairs, gates each cell's accumulate with systolic skew and
//               hands results out one row per valid/ready beat.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-high
//               bus   - mac_array_sequencer_if.slave (command, status,
//                       operand reads, array control, result handshake)
// Revision    : 1.0 - initial release
// ============================================================================
module mac_array_sequencer
    import mac_ctrl_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int K_WIDTH    = DEF_K_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  wire logic               clk,
    input  wire logic               reset,
    mac_array_sequencer_if.slave    bus
);

    localparam int DEPTH = skew_depth(ROWS, COLS);
    localparam int ROW_W = clog2_min1(ROWS);

    state_e                 state_q;
    logic [K_WIDTH-1:0]     k_len_q;
    logic                   rd_en_q;
    logic [ADDR_WIDTH-1:0]  rd_addr_q;
    logic                   mac_clear_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   out_valid_q;
    logic [ROW_W-1:0]       out_row_q;

    logic [DEPTH:1]         w_d;
    logic                   w_pipe_empty;
    logic                   w_last_step;
    logic [ROWS*COLS-1:0]   w_hold;

    skew_valid_pipe #(
        .DEPTH (DEPTH)
    ) u_skew (
        .clk     (clk),
        .reset   (reset),
        .rd_en_i (rd_en_q),
        .d_o     (w_d),
        .empty_o (w_pipe_empty)
    );

    // rd_addr doubles as the step counter. It is ADDR_WIDTH wide and only
    // ever reaches k_len, so k_len = 2^K_WIDTH-1 cannot wrap it.
    assign w_last_step = (rd_addr_q + ADDR_WIDTH'(1)) == ADDR_WIDTH'(k_len_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            mac_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
        end else begin
            done_q      <= 1'b0;
            mac_clear_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // The done cycle is itself an IDLE cycle; a start seen
                    // alongside done is dropped.
                    if (bus.start && !done_q) begin
                        k_len_q     <= bus.k_len;
                        rd_addr_q   <= '0;
                        mac_clear_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (k_len_q != '0) begin
                        rd_en_q <= 1'b1;
                        state_q <= S_FEED;
                    end else begin
                        out_valid_q <= 1'b1;
                        out_row_q   <= '0;
                        state_q     <= S_OUTPUT;
                    end
                end
                S_FEED: begin
                    rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
                    if (w_last_step) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pipe_empty) begin
                        out_valid_q <= 1'b1;
                        out_row_q   <= '0;
                        state_q     <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (bus.out_ready) begin
                        if (out_row_q == ROW_W'(ROWS - 1)) begin
                            out_valid_q <= 1'b0;
                            out_row_q   <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            out_row_q <= out_row_q + ROW_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Cell (r,c) sees its operands 1+r+c cycles after the buffer read.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign w_hold[r*COLS + c] = ~w_d[1 + r + c];
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.a_rd_en   = rd_en_q;
    assign bus.b_rd_en   = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.mac_clear = mac_clear_q;
    assign bus.mac_hold  = w_hold;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;

endmodule : mac_array_sequencer
`default_nettype wire

// File: tb/tb_mac_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_array_sequencer
// Description : Self-checking bench for mac_array_sequencer. A cycle-level
//               model derives every output from the command start cycle,
//               k_len and the handshake history; directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_array_sequencer;
    import mac_ctrl_pkg::*;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int K_WIDTH    = 8;
    localparam int ADDR_WIDTH = 8;
    localparam int CELLS      = ROWS * COLS;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_array_sequencer_if #(
        .ROWS(ROWS), .COLS(COLS), .K_WIDTH(K_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) bus ();

    mac_array_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .K_WIDTH(K_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model state ----------------
    bit  m_active   = 0;
    int  m_t0       = 0;
    int  m_k        = 0;
    int  m_acc      = 0;
    int  m_done_cyc = -1;

    // ---------------- per-command records ----------------
    int rec_t0, rec_clear, rec_rd_first, rec_rd_last, rec_rd_cnt, rec_rd_last_addr;
    int rec_h0_first, rec_h0_last, rec_h15_first, rec_h15_last;
    int rec_valid_first, rec_row1_cnt, rec_done;
    int hold_cnt [CELLS];
    int acc_rows [$];

    task automatic clear_records();
        rec_clear = -1; rec_rd_first = -1; rec_rd_last = -1; rec_rd_cnt = 0;
        rec_rd_last_addr = -1;
        rec_h0_first = -1; rec_h0_last = -1; rec_h15_first = -1; rec_h15_last = -1;
        rec_valid_first = -1; rec_row1_cnt = 0; rec_done = -1;
        for (int i = 0; i < CELLS; i++) hold_cnt[i] = 0;
        acc_rows.delete();
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int n;
        int ov;
        int lo_first;
        int lo_last;
        logic [CELLS-1:0] e_hold;
        bit e_rd;
        bit e_valid;
        bit e_done;
        if (reset) begin
            m_active   = 0;
            m_done_cyc = -1;
        end else begin
            n  = cyc - m_t0;
            ov = (m_k > 0) ? m_k + ROWS + COLS + 1 : 2;
            e_rd    = m_active && (m_k > 0) && (n >= 2) && (n <= m_k + 1);
            e_valid = m_active && (n >= ov);
            e_done  = !m_active && (cyc == m_done_cyc);
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    lo_first = 3 + r + c;
                    lo_last  = m_k + 2 + r + c;
                    e_hold[r*COLS + c] = !(m_active && n >= lo_first && n <= lo_last);
                end
            end
            check("busy",      bus.busy,      m_active);
            check("done",      bus.done,      e_done);
            check("mac_clear", bus.mac_clear, m_active && n == 1);
            check("a_rd_en",   bus.a_rd_en,   e_rd);
            check("b_rd_en",   bus.b_rd_en,   e_rd);
            check("mac_hold",  bus.mac_hold,  e_hold);
            check("out_valid", bus.out_valid, e_valid);
            if (e_rd)    check("rd_addr", bus.rd_addr, n - 2);
            if (e_valid) check("out_row", bus.out_row, m_acc);

            // records of what the DUT actually did
            if (bus.mac_clear && rec_clear < 0) rec_clear = cyc;
            if (bus.a_rd_en) begin
                if (rec_rd_first < 0) rec_rd_first = cyc;
                rec_rd_last = cyc;
                rec_rd_cnt++;
                rec_rd_last_addr = int'(bus.rd_addr);
            end
            for (int i = 0; i < CELLS; i++) if (!bus.mac_hold[i]) hold_cnt[i]++;
            if (!bus.mac_hold[0]) begin
                if (rec_h0_first < 0) rec_h0_first = cyc;
                rec_h0_last = cyc;
            end
            if (!bus.mac_hold[CELLS-1]) begin
                if (rec_h15_first < 0) rec_h15_first = cyc;
                rec_h15_last = cyc;
            end
            if (bus.out_valid && rec_valid_first < 0) rec_valid_first = cyc;
            if (bus.out_valid && bus.out_row == 1) rec_row1_cnt++;
            if (bus.done) rec_done = cyc;

            // advance the model with this cycle's inputs
            if (e_valid && bus.out_ready) begin
                acc_rows.push_back(int'(bus.out_row));
                m_acc++;
                if (m_acc == ROWS) begin
                    m_active   = 0;
                    m_done_cyc = cyc + 1;
                end
            end else if (!m_active && bus.start && cyc != m_done_cyc) begin
                m_active = 1;
                m_t0     = cyc;
                m_k      = int'(bus.k_len);
                m_acc    = 0;
                clear_records();
                rec_t0   = cyc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_cmd(input int k);
        bus.start = 1'b1;
        bus.k_len = K_WIDTH'(k);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        check("done_timeout", seen, 1);
        tick();
    endtask

    task automatic wait_valid(input int max_cyc);
        for (int i = 0; i < max_cyc && !bus.out_valid; i++) tick();
        check("valid_timeout", bus.out_valid, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},      bus.busy,      0);
        check({tag, "_done"},      bus.done,      0);
        check({tag, "_a_rd_en"},   bus.a_rd_en,   0);
        check({tag, "_b_rd_en"},   bus.b_rd_en,   0);
        check({tag, "_rd_addr"},   bus.rd_addr,   0);
        check({tag, "_mac_clear"}, bus.mac_clear, 0);
        check({tag, "_mac_hold"},  bus.mac_hold,  16'hFFFF);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_row"},   bus.out_row,   0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int hold_sum;
        bus.start     = 1'b0;
        bus.k_len     = '0;
        bus.out_ready = 1'b1;
        clear_records();
        reset = 1'b1;
        repeat (2) tick();
        check_reset_vals("rst0");
        reset = 1'b0;
        tick();

        // Basic k_len=3 timing, offsets from the start-sample cycle.
        start_cmd(3);
        wait_done(100);
        check("t1_clear",    rec_clear     - rec_t0, 1);
        check("t1_rd_first", rec_rd_first  - rec_t0, 2);
        check("t1_rd_last",  rec_rd_last   - rec_t0, 4);
        check("t1_rd_addr",  rec_rd_last_addr,       2);
        check("t1_h0_first", rec_h0_first  - rec_t0, 3);
        check("t1_h0_last",  rec_h0_last   - rec_t0, 5);
        check("t1_h15_first", rec_h15_first - rec_t0, 9);
        check("t1_h15_last", rec_h15_last  - rec_t0, 11);
        check("t1_valid",    rec_valid_first - rec_t0, 12);
        check("t1_done",     rec_done      - rec_t0, 16);
        check("t1_rows",     acc_rows.size(), 4);

        // k_len=0: straight to OUTPUT, no reads, no accumulates.
        start_cmd(0);
        wait_done(50);
        hold_sum = 0;
        for (int i = 0; i < CELLS; i++) hold_sum += hold_cnt[i];
        check("k0_rd_cnt",   rec_rd_cnt, 0);
        check("k0_hold_sum", hold_sum, 0);
        check("k0_valid",    rec_valid_first - rec_t0, 2);
        check("k0_done",     rec_done - rec_t0, 6);
        check("k0_rows",     acc_rows.size(), 4);

        // Backpressure: stall row 1 for 5 cycles.
        start_cmd(1);
        wait_valid(50);
        tick();
        bus.out_ready = 1'b0;
        repeat (5) tick();
        bus.out_ready = 1'b1;
        wait_done(50);
        check("bp_row1_cycles", rec_row1_cnt, 6);
        check("bp_rows", acc_rows.size(), 4);
        for (int i = 0; i < acc_rows.size(); i++) check("bp_row_order", acc_rows[i], i);

        // start while busy (FEED and OUTPUT) is ignored.
        start_cmd(4);
        tick();
        tick();
        bus.start = 1'b1;
        bus.k_len = 8'd9;
        tick();
        bus.start = 1'b0;
        wait_valid(50);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(50);
        check("busy_rd_cnt", rec_rd_cnt, 4);
        check("busy_done",   rec_done - rec_t0, 17);

        // Asynchronous reset at FEED step 2 of k_len=5.
        start_cmd(5);
        tick();
        tick();
        tick();
        check("pre_rst_addr", bus.rd_addr, 2);
        reset = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        tick();
        reset = 1'b0;
        tick();
        start_cmd(5);
        wait_done(100);
        check("rerun_rd_cnt",  rec_rd_cnt, 5);
        check("rerun_valid",   rec_valid_first - rec_t0, 14);
        check("rerun_done",    rec_done - rec_t0, 18);
        check("rerun_h15_cnt", hold_cnt[CELLS-1], 5);

        // Maximum k_len: no wrap of the step counter.
        start_cmd(255);
        wait_done(400);
        check("k255_rd_cnt",   rec_rd_cnt, 255);
        check("k255_last_addr", rec_rd_last_addr, 254);
        check("k255_end_addr", bus.rd_addr, 255);
        check("k255_done",     rec_done - rec_t0, 268);
        for (int i = 0; i < CELLS; i++) check("k255_hold_cnt", hold_cnt[i], 255);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mac_array_sequencer
`default_nettype wire
